// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - core/DMA arbiter for the mem_ctrl write port and read address
module mem_port_arb #(
    parameter int unsigned              ADDR_WIDTH  = 8,
    parameter int unsigned              DATA_WIDTH  = 8,
    parameter int unsigned              MAX_WAIT    = 3,
    parameter logic [ADDR_WIDTH-1:0]    STATUS_ADDR = 'h01
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_rvalid,
    output logic                  dma_err,
    output logic [ADDR_WIDTH-1:0] writeaddr,
    output logic [DATA_WIDTH-1:0] writedata,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] readaddr,
    input  logic [DATA_WIDTH-1:0] readdata
);

    typedef enum logic {CORE_PRI, DMA_FORCE} state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0]   dma_rdata_q, dma_rdata_d;
    logic                    dma_rvalid_q, dma_rvalid_d;
    logic                    dma_err_q, dma_err_d;
    logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
    logic                    dma_status_wr;

    assign dma_status_wr = dma_we && (dma_addr == STATUS_ADDR);
    assign core_rdata    = readdata;
    assign dma_rdata     = dma_rdata_q;
    assign dma_rvalid    = dma_rvalid_q;
    assign dma_err       = dma_err_q;

    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (!reset) begin
            if (dma_req && (!core_req || state_q == DMA_FORCE)) begin
                dma_gnt = 1'b1;
            end else if (core_req) begin
                core_gnt = 1'b1;
            end
        end
    end

    // With no winner the read address parks on the last granted address.
    always_comb begin
        write_en  = 1'b0;
        writeaddr = last_addr_q;
        writedata = core_wdata;
        readaddr  = last_addr_q;
        if (reset) begin
            writeaddr = '0;
            writedata = '0;
            readaddr  = '0;
        end else if (dma_gnt) begin
            writeaddr = dma_addr;
            writedata = dma_wdata;
            readaddr  = dma_addr;
            write_en  = dma_we && !dma_status_wr;
        end else if (core_gnt) begin
            writeaddr = core_addr;
            writedata = core_wdata;
            readaddr  = core_addr;
            write_en  = core_we;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        dma_rvalid_d = dma_gnt && !dma_we;
        dma_err_d    = dma_gnt && dma_status_wr;
        dma_rdata_d  = dma_rvalid_d ? readdata : dma_rdata_q;
        last_addr_d  = (core_gnt || dma_gnt) ? readaddr : last_addr_q;

        if (dma_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (dma_req && wait_cnt_q != 4'd15) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        case (state_q)
            CORE_PRI: begin
                if (wait_cnt_d >= MAX_WAIT_C) begin
                    state_d = DMA_FORCE;
                end
            end
            DMA_FORCE: begin
                if (dma_gnt) begin
                    state_d = CORE_PRI;
                end else if (!dma_req) begin
                    // A request withdrawn while forced is tolerated: start over.
                    state_d    = CORE_PRI;
                    wait_cnt_d = 4'd0;
                end
            end
            default: state_d = CORE_PRI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CORE_PRI;
            wait_cnt_q   <= 4'd0;
            dma_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
            dma_err_q    <= 1'b0;
            last_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            dma_rdata_q  <= dma_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_err_q    <= dma_err_d;
            last_addr_q  <= last_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - self-checking bench for mem_port_arb with a memory model
module tb_mem_port_arb;

    localparam int         MAX_WAIT = 3;
    localparam logic [7:0] STATUS   = 8'h01;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_req, core_we;
    logic [7:0] core_addr, core_wdata;
    logic       core_gnt;
    logic [7:0] core_rdata;
    logic       dma_req, dma_we;
    logic [7:0] dma_addr, dma_wdata;
    logic       dma_gnt;
    logic [7:0] dma_rdata;
    logic       dma_rvalid, dma_err;
    logic [7:0] writeaddr, writedata, readaddr, readdata;
    logic       write_en;

    mem_port_arb #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_WAIT(MAX_WAIT), .STATUS_ADDR(STATUS)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_err(dma_err),
        .writeaddr(writeaddr), .writedata(writedata), .write_en(write_en),
        .readaddr(readaddr), .readdata(readdata)
    );

    always #5 clk = ~clk;

    // Stand-in for mem_ctrl: asynchronous read, write on the rising edge.
    logic [7:0] mem_env [256];
    logic       tb_clear;
    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < 256; i++) mem_env[i] <= 8'h00;
        end else if (write_en) begin
            mem_env[writeaddr] <= writedata;
        end
    end
    assign readdata = mem_env[readaddr];

    // Reference model: expected memory contents and DMA denial streak.
    logic [7:0] ref_mem [256];
    int         streak;
    logic       exp_rv, exp_err;
    logic [7:0] exp_drd;
    bit         regs_known;
    logic       last_dg;

    int n_tests, n_fail;
    logic       s_cg, s_dg, s_we, s_rv, s_err;
    logic [7:0] s_crd, s_drd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic cr, input logic cw, input logic [7:0] ca,
                        input logic [7:0] cd, input logic dr, input logic dw,
                        input logic [7:0] da, input logic [7:0] dd);
        logic       m_cg, m_dg, m_we;
        logic [7:0] m_addr;
        @(negedge clk);
        reset = r; core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        #1;
        s_cg = core_gnt; s_dg = dma_gnt; s_we = write_en; s_rv = dma_rvalid;
        s_err = dma_err; s_crd = core_rdata; s_drd = dma_rdata;
        m_dg   = !r && dr && (!cr || streak >= MAX_WAIT);
        m_cg   = !r && cr && !m_dg;
        m_we   = (m_cg && cw) || (m_dg && dw && da != STATUS);
        m_addr = m_dg ? da : ca;
        chk("core_gnt", core_gnt, m_cg);
        chk("dma_gnt", dma_gnt, m_dg);
        chk("write_en", write_en, m_we);
        if (r) begin
            chk("readaddr_rst", readaddr, 0);
            chk("writeaddr_rst", writeaddr, 0);
            chk("writedata_rst", writedata, 0);
        end else if (m_cg || m_dg) begin
            chk("readaddr", readaddr, m_addr);
            chk("writeaddr", writeaddr, m_addr);
            if (m_we) chk("writedata", writedata, m_dg ? dd : cd);
        end
        if (m_cg && !cw) chk("core_rdata", core_rdata, ref_mem[ca]);
        if (regs_known) begin
            chk("dma_rvalid", dma_rvalid, exp_rv);
            chk("dma_err", dma_err, exp_err);
            chk("dma_rdata", dma_rdata, exp_drd);
        end
        @(posedge clk);
        if (r) begin
            streak = 0; exp_rv = 1'b0; exp_err = 1'b0; exp_drd = 8'h00; regs_known = 1'b1;
        end else begin
            exp_rv  = m_dg && !dw;
            exp_err = m_dg && dw && da == STATUS;
            if (exp_rv) exp_drd = ref_mem[da];
            if (m_we) ref_mem[m_addr] = m_dg ? dd : cd;
            if (m_dg) streak = 0;
            else if (dr) streak = (streak < 15) ? streak + 1 : 15;
            else if (streak >= MAX_WAIT) streak = 0;
        end
        last_dg = m_dg;
    endtask

    typedef struct {
        logic       cr, cw; logic [7:0] ca, cd;
        logic       dr, dw; logic [7:0] da, dd;
        logic       e_cg, e_dg, e_we, e_rv, e_err;
        logic       c_crd; logic [7:0] e_crd;
        logic       c_drd; logic [7:0] e_drd;
    } vec_t;

    vec_t       vt [15];
    logic [7:0] pool [6];

    initial begin
        n_tests = 0; n_fail = 0; streak = 0; regs_known = 1'b0;
        exp_rv = 1'b0; exp_err = 1'b0; exp_drd = 8'h00; last_dg = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        pool[0] = 8'h01; pool[1] = 8'h10; pool[2] = 8'h20;
        pool[3] = 8'h30; pool[4] = 8'h40; pool[5] = 8'h41;

        vt[0]  = '{1'b1,1'b1,8'h10,8'd32, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00};
        vt[1]  = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,8'd32, 1'b0,8'h00};
        vt[2]  = '{1'b1,1'b1,8'h20,8'hA5, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00};
        vt[3]  = '{1'b1,1'b1,8'h01,8'h45, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00};
        vt[4]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h20,8'h00, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00};
        vt[5]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,8'h00, 1'b1,8'hA5};
        vt[6]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,8'h00, 1'b1,8'hA5};
        vt[7]  = '{1'b1,1'b0,8'h10,8'h00, 1'b1,1'b1,8'h30,8'h5C, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,8'd32, 1'b0,8'h00};
        vt[8]  = vt[7];
        vt[9]  = vt[7];
        vt[10] = '{1'b1,1'b0,8'h10,8'h00, 1'b1,1'b1,8'h30,8'h5C, 1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00};
        vt[11] = '{1'b1,1'b0,8'h30,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,8'h5C, 1'b0,8'h00};
        vt[12] = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h01,8'h22, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00};
        vt[13] = '{1'b1,1'b0,8'h01,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,8'h45, 1'b0,8'h00};
        vt[14] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,8'h00, 1'b1,8'hA5};

        reset = 1'b1; tb_clear = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        tb_clear = 1'b0;
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("reset_rvalid", s_rv, 0);
        chk("reset_err", s_err, 0);
        chk("reset_drd", s_drd, 0);

        for (int i = 0; i < 15; i++) begin
            step(1'b0, vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
            chk($sformatf("vec%0d_cg", i), s_cg, vt[i].e_cg);
            chk($sformatf("vec%0d_dg", i), s_dg, vt[i].e_dg);
            chk($sformatf("vec%0d_we", i), s_we, vt[i].e_we);
            chk($sformatf("vec%0d_rv", i), s_rv, vt[i].e_rv);
            chk($sformatf("vec%0d_err", i), s_err, vt[i].e_err);
            if (vt[i].c_crd) chk($sformatf("vec%0d_crd", i), s_crd, vt[i].e_crd);
            if (vt[i].c_drd) chk($sformatf("vec%0d_drd", i), s_drd, vt[i].e_drd);
        end

        // Reset with a partial starvation count and both requests pending.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
            chk("rst_mid_cg", s_cg, 0);
            chk("rst_mid_dg", s_dg, 0);
            chk("rst_mid_we", s_we, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
            chk($sformatf("post_rst%0d_dg", i), s_dg, (i == 3));
            chk($sformatf("post_rst%0d_cg", i), s_cg, (i != 3));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("post_rst_rv", s_rv, 1);
        chk("post_rst_drd", s_drd, 8'hA5);

        // Random traffic; DMA holds each request until it is granted.
        begin
            logic       d_pend, d_we_r;
            logic [7:0] d_addr_r, d_data_r;
            d_pend = 1'b0; d_we_r = 1'b0; d_addr_r = 8'h00; d_data_r = 8'h00;
            for (int c = 0; c < 800; c++) begin
                logic r, cr, cw;
                logic [7:0] ca, cd;
                if (d_pend && last_dg) d_pend = 1'b0;
                if (!d_pend && $urandom_range(0, 2) == 0) begin
                    d_pend   = 1'b1;
                    d_we_r   = 1'($urandom_range(0, 1));
                    d_addr_r = pool[$urandom_range(0, 5)];
                    d_data_r = 8'($urandom);
                end
                r  = ($urandom_range(0, 99) == 0);
                cr = ($urandom_range(0, 3) != 0);
                cw = 1'($urandom_range(0, 1));
                ca = pool[$urandom_range(0, 5)];
                cd = 8'($urandom);
                step(r, cr, cw, ca, cd, d_pend, d_we_r, d_addr_r, d_data_r);
                if (r) last_dg = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbitrates the single write port and single read address of mem_ctrl between two requesters: the core pipeline and a DMA/debug engine.
- Core has default priority. A starvation counter guarantees DMA progress under continuous core traffic.
- DMA writes to the status/bank register are blocked, so DMA can never change bank, C or Z.
- Sits between the core/DMA and mem_ctrl; the accumulator and flag ports of mem_ctrl bypass this block.

Parameters:
- ADDR_WIDTH, 8, address width of mem_ctrl ports.
- DATA_WIDTH, 8, data width.
- MAX_WAIT, 3, consecutive denied DMA-request cycles before DMA is forced to win (legal range 1..15).
- STATUS_ADDR, 8'h01, address of the status/bank register; DMA writes to it are blocked.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core requests an access this cycle.
- core_we  in  1  1=write, 0=read.
- core_addr  in  ADDR_WIDTH  core address.
- core_wdata  in  DATA_WIDTH  core write data.
- core_gnt  out  1  core access performed this cycle (combinational).
- core_rdata  out  DATA_WIDTH  readdata passthrough, valid when core_gnt & !core_we.
- dma_req  in  1  DMA requests an access; held until granted.
- dma_we  in  1  1=write, 0=read.
- dma_addr  in  ADDR_WIDTH  DMA address.
- dma_wdata  in  DATA_WIDTH  DMA write data.
- dma_gnt  out  1  DMA access accepted this cycle (combinational).
- dma_rdata  out  DATA_WIDTH  registered read data.
- dma_rvalid  out  1  one-cycle pulse: dma_rdata valid (cycle after the granted read).
- dma_err  out  1  one-cycle pulse: the previous granted DMA write hit STATUS_ADDR and was dropped.
- writeaddr  out  ADDR_WIDTH  to mem_ctrl.
- writedata  out  DATA_WIDTH  to mem_ctrl.
- write_en  out  1  to mem_ctrl.
- readaddr  out  ADDR_WIDTH  to mem_ctrl.
- readdata  in  DATA_WIDTH  from mem_ctrl (asynchronous read of readaddr).

Behaviour:
- Reset (synchronous):
  - State returns to CORE_PRI; wait_cnt=0.
  - dma_rdata=0, dma_rvalid=0, dma_err=0.
  - While reset is high, core_gnt, dma_gnt and write_en are forced to 0; writeaddr, writedata and readaddr are driven to 0.
  - A request pending at reset is dropped. The requester must keep req high to retry after reset.
- FSM states:
  - CORE_PRI: core wins ties.
  - DMA_FORCE: DMA wins ties.
- Grant (combinational, one access per cycle):
  - Only one requester → it is granted.
  - Both requesting → CORE_PRI grants core, DMA_FORCE grants DMA.
  - Neither requesting → no grant; write_en=0, readaddr holds the last granted address.
- Mux to mem_ctrl:
  - writeaddr, readaddr = winner's address.
  - writedata = winner's wdata.
  - write_en = winner_we & grant, except a DMA write to STATUS_ADDR, which forces write_en=0.
- Write latency: the write commits at the rising edge ending the grant cycle. A read in the next cycle returns the new value.
- Core reads: zero latency; core_rdata = readdata in the grant cycle.
- DMA reads:
  - readdata is captured into dma_rdata at the grant-cycle edge; dma_rvalid=1 for exactly one cycle afterwards.
  - dma_rdata holds its value until the next DMA read.
- Blocked DMA write to STATUS_ADDR:
  - dma_gnt is still asserted, so the request is consumed.
  - dma_err=1 in the following cycle.
  - No memory change occurs.
- wait_cnt (4-bit):
  - Increments each cycle dma_req=1 & dma_gnt=0, saturating at 15.
  - Clears on dma_gnt.
- Transitions:
  - CORE_PRI→DMA_FORCE when wait_cnt reaches MAX_WAIT at a clock edge.
  - DMA_FORCE→CORE_PRI on the edge after any dma_gnt.
  - DMA_FORCE with dma_req dropped (illegal, but tolerated) → return to CORE_PRI and clear wait_cnt.
- DMA is denied at most MAX_WAIT consecutive cycles. The core is denied at most 1 cycle per forced grant.
- dma_req must stay asserted with stable address and data until dma_gnt. The core may change its request freely.

Test Plan:
- Core-only: core write 8'd32 to 8'h10, next cycle core read 8'h10 → core_gnt both cycles, core_rdata=8'd32, dma_gnt=0.
- DMA-only read: preload 8'h20=8'hA5; dma_req read 8'h20 → dma_gnt same cycle; next cycle dma_rvalid=1, dma_rdata=8'hA5; rvalid low after one cycle.
- Starvation, MAX_WAIT=3: core_req held high, dma_req write 8'h30←8'h5C → DMA denied 3 cycles, granted on the 4th, core denied exactly that cycle; 8'h30 reads back 8'h5C; state back to CORE_PRI.
- Status protection: DMA write 8'h01←8'b00100010 → dma_gnt=1, write_en=0, dma_err pulses next cycle; core read of 8'h01 unchanged (bank, C, Z intact).
- Reset mid-operation: assert reset with wait_cnt=2 and both requests high → all grants and write_en 0 during reset; after release, CORE_PRI and full MAX_WAIT count before DMA is forced.
